aes_key_sched_mc: RTL
=====================

# aes_key_sched_mc

Multi-context AES key schedule supporting AES-128, AES-192 and AES-256. It expands one cipher key per request, one 32-bit word per cycle, into a selected key slot. It holds up to `NUM_SLOTS` expanded keys and serves 128-bit round keys to the cipher datapath through a combinational read port. SubWord uses an external shared S-box through the `sboxw`/`new_sboxw` pair, as in the existing core.

## Interface
Parameters:
- `NUM_SLOTS`, 2: number of independent key contexts, 1..8.
- `SLOT_W`, `$clog2(NUM_SLOTS)` (minimum 1): width of the slot indices.

Ports:
- `clk`  in  1  clock; all registers update on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init`  in  1  expansion request; accepted only when `ready`=1.
- `init_slot`  in  SLOT_W  target slot, sampled on acceptance.
- `keylen`  in  2  key length, sampled on acceptance: 0=128, 1=192, 2=256, 3=reserved.
- `key`  in  256  cipher key, MSB-justified: 128-bit in [255:128], 192-bit in [255:64].
- `ready`  out  1  high when idle and able to accept `init`.
- `err`  out  1  one-cycle pulse when `init` is rejected.
- `key_valid`  out  NUM_SLOTS  per-slot flag: expanded key complete.
- `rd_slot`  in  SLOT_W  slot selector for the read port.
- `round`  in  4  round index for the read port.
- `round_key`  out  128  words w[4·round .. 4·round+3] of `rd_slot`, combinational.
- `sboxw`  out  32  word sent to the external S-box.
- `new_sboxw`  in  32  S-box result, combinational, same cycle.

## Operation
- Nk/Nr per key length: 128 → 4/10, 192 → 6/12, 256 → 8/14. Words to generate: Nw = 4·(Nr+1), i.e. 44, 52 or 60.
- FSM states: IDLE, GEN, DONE.
- **IDLE**
  - `init`=1 with `keylen`≠3: latch slot, keylen and key. Clear `key_valid[init_slot]`, set i=0, rcon=0x01, go to GEN.
  - `init`=1 with `keylen`=3: `err`=1 for the next cycle, no other state change.
  - `init_slot` ≥ NUM_SLOTS is also rejected with `err`.
- **GEN**: write w[i] to the slot each cycle, i=0..Nw-1.
  - i<Nk: w[i] is key word i, taken from the MSB end.
  - Otherwise: w[i] = w[i-Nk] ^ t, where t is:
    - SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod Nk = 0; rcon ← xtime(rcon) after use.
    - SubWord(w[i-1]) when Nk=8 and i mod 8 = 4.
    - w[i-1] otherwise.
  - SubWord is computed as `new_sboxw` with `sboxw`=w[i-1]. RotWord is applied after SubWord (the two commute).
  - An 8-word sliding window register holds w[i-8..i-1].
  - At i=Nw-1 go to DONE.
- **DONE**: set `key_valid[slot]`, store slot keylen, `ready`←1, go to IDLE.
- `init` while busy (GEN or DONE): ignored, no `err`.
- Read port: `round_key`=0 when `key_valid[rd_slot]`=0 or `round` > Nr of the stored slot keylen.
- Reading other slots is unaffected during an expansion.
- `sboxw`=w[i-1] in GEN, 0 otherwise.

## Timing
- Acceptance edge E0. GEN covers E1..ENw, writing one word per edge. DONE is at E(Nw+1).
- `ready`=0 from E0 until E(Nw+1), i.e. 45/53/61 cycles for 128/192/256.
- `key_valid[slot]` rises at the same edge as `ready`.
- `err` is high during the cycle after the rejecting edge.
- Reset values:
  - `ready`=1, `err`=0, `key_valid`=0, `sboxw`=0.
  - `round_key`=0, because all slots are invalid.
  - FSM=IDLE, rcon=0x01.
  - Word storage is not reset.
- Reset mid-expansion aborts immediately; all slots become invalid.
- Back-to-back: `init` held high is accepted again on the first cycle `ready`=1.
- Re-expanding a valid slot invalidates it at E0.

## Structure
- Package `aes_key_pkg` holds:
  - keylen encodings;
  - FSM state encoding;
  - Nk/Nr/Nw lookup functions;
  - the xtime function;
  - constants MAX_WORDS=60 and MAX_ROUNDS=14.
- Sub-module `aes_key_word_store` holds:
  - NUM_SLOTS×60×32 storage;
  - a one-word write port (slot, index);
  - a 4-word combinational read port (slot, round).
- The top level holds the FSM, the word window, the rcon register, per-slot valid and keylen registers, and the output gating.

## Test plan
- **AES-128**, key 2b7e151628aed2a6abf7158809cf4f3c into slot 0:
  - `ready` low 45 cycles;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - round 11 = 0.
- **AES-192**, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b into slot 1:
  - `ready` low 53 cycles;
  - round 12 = e98ba06f448c773c8ecc720401002202.
- **AES-256**, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 into slot 0 while slot 1 holds the 192 key:
  - round 14 = fe4890d1e6188d0b046df344706c631e;
  - slot 1 round 12 unchanged throughout.
- **Reserved keylen**, `keylen`=3: `err` pulses 1 cycle; `ready` stays 1; `key_valid` unchanged.
- **Busy init**, `init` mid-GEN with a different slot: ignored; the original expansion completes with correct keys.
- **Reset mid-expansion**, `reset_n` low at cycle 20 of a 256 expansion:
  - `key_valid`=0, `ready`=1, `round_key`=0;
  - a fresh expansion then succeeds.

Source files
------------

// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared encodings, key-length lookups and GF(2^8) helper for the key schedule
package aes_key_pkg;

  localparam int MAX_WORDS  = 60;
  localparam int MAX_ROUNDS = 14;

  typedef enum logic [1:0] {
    KEYLEN_128  = 2'd0,
    KEYLEN_192  = 2'd1,
    KEYLEN_256  = 2'd2,
    KEYLEN_RSVD = 2'd3
  } keylen_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: return 4'd4;
      KEYLEN_192: return 4'd6;
      default:    return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: return 4'd10;
      KEYLEN_192: return 4'd12;
      default:    return 4'd14;
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_128: return 6'd44;
      KEYLEN_192: return 6'd52;
      default:    return 6'd60;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_mc_if.sv
// rtl/aes_key_sched_mc_if.sv - expansion request handshake and slot status bundle
interface aes_key_sched_mc_if #(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = 1
);
  logic                 init;
  logic [SLOT_W-1:0]    init_slot;
  logic [1:0]           keylen;
  logic [255:0]         key;
  logic                 ready;
  logic                 err;
  logic [NUM_SLOTS-1:0] key_valid;

  modport master (output init, init_slot, keylen, key, input ready, err, key_valid);
  modport slave  (input init, init_slot, keylen, key, output ready, err, key_valid);
endinterface

// File: rtl/aes_key_word_store.sv
// rtl/aes_key_word_store.sv - per-slot expanded key word storage, one-word write, four-word read
module aes_key_word_store
  import aes_key_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [5:0]        wr_idx,
  input  logic [31:0]       wr_data,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [3:0]        rd_round,
  output logic [127:0]      rd_data
);

  logic [31:0] mem [NUM_SLOTS][MAX_WORDS];
  logic [5:0]  base;

  always_ff @(posedge clk) begin
    if (we) mem[wr_slot][wr_idx] <= wr_data;
  end

  // Rounds past the largest schedule would index beyond the array, so they read as zero.
  always_comb begin
    base    = {rd_round, 2'b00};
    rd_data = '0;
    if (rd_round <= 4'(MAX_ROUNDS))
      rd_data = {mem[rd_slot][base], mem[rd_slot][base + 6'd1],
                 mem[rd_slot][base + 6'd2], mem[rd_slot][base + 6'd3]};
  end

endmodule

// File: rtl/aes_key_sched_mc.sv
// rtl/aes_key_sched_mc.sv - multi-context AES-128/192/256 key expansion, one word per cycle
module aes_key_sched_mc
  import aes_key_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  aes_key_sched_mc_if.slave   req,
  input  logic [SLOT_W-1:0]   rd_slot,
  input  logic [3:0]          round,
  output logic [127:0]        round_key,
  output logic [31:0]         sboxw,
  input  logic [31:0]         new_sboxw
);

  state_e               state_q, state_d;
  logic                 accept, reject, we, slot_ok, rcon_use, rd_ok;
  logic [SLOT_W-1:0]    slot_q;
  logic [1:0]           keylen_q;
  logic [255:0]         key_q;
  logic [5:0]           idx_q;
  logic [2:0]           mod_q;
  logic [7:0]           rcon_q;
  logic [31:0]          win_q [8];
  logic [NUM_SLOTS-1:0] key_valid_q;
  logic [1:0]           slot_kl_q [NUM_SLOTS];
  logic                 err_q;
  logic [3:0]           nk;
  logic [31:0]          new_word, w_old;
  logic [127:0]         store_data;

  assign slot_ok = ({1'b0, req.init_slot} < (SLOT_W+1)'(NUM_SLOTS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.init) begin
          if (req.keylen == KEYLEN_RSVD || !slot_ok) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        we = 1'b1;
        if (idx_q == nw_of(keylen_q) - 6'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // win_q[0] is w[i-1]; win_q[k] is w[i-1-k], so w[i-Nk] sits at win_q[Nk-1].
  always_comb begin
    nk       = nk_of(keylen_q);
    w_old    = win_q[3'(nk - 4'd1)];
    rcon_use = 1'b0;
    if (idx_q < 6'(nk)) begin
      new_word = key_q[255:224];
    end else if (mod_q == 3'd0) begin
      new_word = w_old ^ {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0};
      rcon_use = 1'b1;
    end else if (nk == 4'd8 && mod_q == 3'd4) begin
      new_word = w_old ^ new_sboxw;
    end else begin
      new_word = w_old ^ win_q[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= '0;
      keylen_q    <= 2'd0;
      key_q       <= '0;
      idx_q       <= 6'd0;
      mod_q       <= 3'd0;
      rcon_q      <= 8'h01;
      key_valid_q <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) slot_kl_q[s] <= 2'd0;
    end else begin
      err_q <= reject;
      if (accept) begin
        slot_q                     <= req.init_slot;
        keylen_q                   <= req.keylen;
        key_q                      <= req.key;
        idx_q                      <= 6'd0;
        mod_q                      <= 3'd0;
        rcon_q                     <= 8'h01;
        key_valid_q[req.init_slot] <= 1'b0;
      end
      if (we) begin
        key_q <= key_q << 32;
        idx_q <= idx_q + 6'd1;
        mod_q <= ({1'b0, mod_q} == nk - 4'd1) ? 3'd0 : mod_q + 3'd1;
        if (rcon_use) rcon_q <= xtime(rcon_q);
        win_q[0] <= new_word;
        for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
      end
      if (state_q == ST_DONE) begin
        key_valid_q[slot_q] <= 1'b1;
        slot_kl_q[slot_q]   <= keylen_q;
      end
    end
  end

  aes_key_word_store #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_store (
    .clk      (clk),
    .we       (we),
    .wr_slot  (slot_q),
    .wr_idx   (idx_q),
    .wr_data  (new_word),
    .rd_slot  (rd_slot),
    .rd_round (round),
    .rd_data  (store_data)
  );

  always_comb begin
    rd_ok = ({1'b0, rd_slot} < (SLOT_W+1)'(NUM_SLOTS)) && key_valid_q[rd_slot]
            && (round <= nr_of(slot_kl_q[rd_slot]));
    round_key = rd_ok ? store_data : '0;
  end

  assign sboxw         = (state_q == ST_GEN) ? win_q[0] : '0;
  assign req.ready     = (state_q == ST_IDLE);
  assign req.err       = err_q;
  assign req.key_valid = key_valid_q;

endmodule
